// File: rtl/mfda_ctrl_pkg.sv
// mfda_ctrl_pkg: shared types and defaults for the mixer/chamber-tree control blocks (rev 1.0).
`default_nettype none

package mfda_ctrl_pkg;

  typedef enum logic [2:0] {
    DS_IDLE   = 3'd0,
    DS_OPEN   = 3'd1,
    DS_DWELL  = 3'd2,
    DS_SETTLE = 3'd3,
    DS_PURGE  = 3'd4,
    DS_DONE   = 3'd5
  } dispense_state_e;

  localparam int DISPENSE_DWELL_DEF  = 4;
  localparam int DISPENSE_SETTLE_DEF = 16;
  localparam int DISPENSE_PURGE_DEF  = 32;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter with a zero flag, shared by every timed phase (rev 1.0).
`default_nettype none

module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Holds at zero so a phase that sees zero stays there until reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/source_dispense_ctrl.sv
// source_dispense_ctrl: timed Source-inlet valve sequencer, N pulses of W cycles then settle (rev 1.0).
// Optional purge phase between SETTLE and DONE is built when DISPENSE_PURGE_EN is defined.
`default_nettype none

module source_dispense_ctrl
  import mfda_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int ON_W       = 8,
  parameter int DWELL_CYC  = DISPENSE_DWELL_DEF,
  parameter int SETTLE_CYC = DISPENSE_SETTLE_DEF,
  parameter int PURGE_CYC  = DISPENSE_PURGE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_pulses,
  input  logic [ON_W-1:0]  cmd_on_cyc,
  input  logic             abort,
  output logic             valve_open,
  output logic             purge_open,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pulses_sent
);

  localparam int MAX_CYC = max2(max2(DWELL_CYC, SETTLE_CYC), PURGE_CYC);
  localparam int TMR_W   = max2(max2(ON_W, $clog2(MAX_CYC)), 1);

  localparam logic [2:0] S_IDLE   = DS_IDLE;
  localparam logic [2:0] S_OPEN   = DS_OPEN;
  localparam logic [2:0] S_DWELL  = DS_DWELL;
  localparam logic [2:0] S_SETTLE = DS_SETTLE;
  localparam logic [2:0] S_DONE   = DS_DONE;
`ifdef DISPENSE_PURGE_EN
  localparam logic [2:0] S_PURGE  = DS_PURGE;
  localparam logic [TMR_W-1:0] PURGE_LD = TMR_W'(PURGE_CYC - 1);
`endif

  // Timer counts down to zero, so each phase loads its length minus one.
  localparam logic [TMR_W-1:0] DWELL_LD  = TMR_W'(DWELL_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [ON_W-1:0]  wm1_q, wm1_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic             aborted_q, aborted_d;
  logic             valve_open_q, valve_open_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;
  logic [ON_W-1:0]  cmd_on_m1;
  logic [CNT_W-1:0] pulses_inc;

  assign cmd_on_m1  = (cmd_on_cyc == '0) ? '0 : cmd_on_cyc - ON_W'(1);
  assign pulses_inc = pulses_q + CNT_W'(1);

  phase_timer #(
    .W(TMR_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    wm1_d     = wm1_q;
    pulses_d  = pulses_q;
    aborted_d = aborted_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          n_d       = cmd_pulses;
          wm1_d     = cmd_on_m1;
          pulses_d  = '0;
          aborted_d = 1'b0;
          if (cmd_pulses == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_OPEN;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(cmd_on_m1);
          end
        end
      end
      S_OPEN: begin
        // Abort wins over pulse completion, so an interrupted pulse is never counted.
        if (abort) begin
          state_d   = S_SETTLE;
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LD;
        end else if (tmr_zero) begin
          pulses_d = pulses_inc;
          tmr_load = 1'b1;
          if (pulses_inc == n_q) begin
            state_d = S_SETTLE;
            tmr_val = SETTLE_LD;
          end else begin
            state_d = S_DWELL;
            tmr_val = DWELL_LD;
          end
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d   = S_SETTLE;
          aborted_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LD;
        end else if (tmr_zero) begin
          state_d  = S_OPEN;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(wm1_q);
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
`ifdef DISPENSE_PURGE_EN
          state_d  = S_PURGE;
          tmr_load = 1'b1;
          tmr_val  = PURGE_LD;
`else
          state_d  = S_DONE;
`endif
        end
      end
`ifdef DISPENSE_PURGE_EN
      S_PURGE: begin
        if (tmr_zero) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are flop outputs aligned with the state.
  assign valve_open_d = (state_d == S_OPEN);
  assign busy_d       = (state_d != S_IDLE);
  assign done_d       = (state_d == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      wm1_q        <= '0;
      pulses_q     <= '0;
      aborted_q    <= 1'b0;
      valve_open_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      wm1_q        <= wm1_d;
      pulses_q     <= pulses_d;
      aborted_q    <= aborted_d;
      valve_open_q <= valve_open_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef DISPENSE_PURGE_EN
  logic purge_open_q;
  logic purge_open_d;

  assign purge_open_d = (state_d == S_PURGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      purge_open_q <= 1'b0;
    end else begin
      purge_open_q <= purge_open_d;
    end
  end

  assign purge_open = purge_open_q;
`else
  assign purge_open = 1'b0;
`endif

  assign cmd_ready   = (state_q == S_IDLE);
  assign valve_open  = valve_open_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign pulses_sent = pulses_q;

endmodule

`default_nettype wire

// File: tb/tb_source_dispense_ctrl.sv
// tb_source_dispense_ctrl: scoreboard bench with a timeline reference model for source_dispense_ctrl.
`default_nettype none

module tb_source_dispense_ctrl;

  localparam int DW = 4;
  localparam int ST = 16;
`ifdef DISPENSE_PURGE_EN
  localparam int PG = 32;
`else
  localparam int PG = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_pulses = '0;
  logic [7:0]  cmd_on_cyc = '0;
  logic        cmd_ready, valve_open, purge_open, busy, done, aborted;
  logic [15:0] pulses_sent;

  source_dispense_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_pulses  (cmd_pulses),
    .cmd_on_cyc  (cmd_on_cyc),
    .abort       (abort),
    .valve_open  (valve_open),
    .purge_open  (purge_open),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int done_off;
    int pulses;
    bit ab;
  } exp_t;

  exp_t sb[$];
  bit   exp_valve[int];
  bit   exp_purge[int];
  bit   exp_busy[int];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Monitor: per-cycle waveform checks and completion checks popped from the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (chk_en) begin
      chk("valve_open", valve_open, exp_valve.exists(cyc));
      chk("purge_open", purge_open, exp_purge.exists(cyc));
      chk("busy", busy, exp_busy.exists(cyc));
      chk("cmd_ready", cmd_ready, !exp_busy.exists(cyc));
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.t + e.done_off);
          chk("pulses_sent", pulses_sent, e.pulses);
          chk("aborted", aborted, e.ab);
        end
      end else if (sb.size() > 0 && cyc > sb[0].t + sb[0].done_off) begin
        chk("done_timeout", done, 1);
        void'(sb.pop_front());
      end
    end
  end

  // Build the expected timeline from the command rules, then drive the command and any abort.
  task automatic issue(input int n, input int w, input int abort_off, input bit hold);
    exp_t e;
    bit   seq[$];
    int   weff, trunc, len, budget;
    weff = (w == 0) ? 1 : w;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < weff; k++) seq.push_back(1'b1);
      if (p != n - 1) for (int k = 0; k < DW; k++) seq.push_back(1'b0);
    end
    len      = seq.size();
    e.ab     = 1'b0;
    e.pulses = n;
    trunc    = len;
    if (n > 0 && abort_off >= 1 && abort_off <= len) begin
      e.ab     = 1'b1;
      trunc    = abort_off;
      e.pulses = 0;
      for (int i = 1; i < abort_off; i++)
        if (seq[i-1] && (i == len || !seq[i])) e.pulses++;
    end
    e.done_off = (n == 0) ? 1 : trunc + ST + PG + 1;

    budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", cmd_ready, 1);
      return;
    end
    cmd_valid  = 1'b1;
    cmd_pulses = 16'(n);
    cmd_on_cyc = 8'(w);
    abort      = (abort_off == 0);
    e.t        = cyc;
    for (int k = 1; k <= trunc; k++) if (seq[k-1]) exp_valve[e.t + k] = 1'b1;
    if (n > 0) for (int k = 1; k <= PG; k++) exp_purge[e.t + trunc + ST + k] = 1'b1;
    for (int k = 1; k <= e.done_off; k++) exp_busy[e.t + k] = 1'b1;
    sb.push_back(e);
    for (int off = 1; off <= e.done_off; off++) begin
      @(negedge clk);
      cmd_valid  = hold;
      cmd_pulses = 16'($urandom_range(0, 5));
      cmd_on_cyc = 8'($urandom_range(0, 9));
      abort      = (off == abort_off);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    #2;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_valve_open", valve_open, 0);
    chk("reset_purge_open", purge_open, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_aborted", aborted, 0);
    chk("reset_pulses_sent", pulses_sent, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    issue(3, 5, -1, 1'b0);
    issue(0, 7, -1, 1'b0);
    issue(3, 5, 7, 1'b0);
    issue(1, 1, -1, 1'b1);
    issue(1, 1, -1, 1'b0);
    issue(2, 0, 1, 1'b0);
    issue(2, 3, 3, 1'b0);
    issue(1, 2, -1, 1'b0);
    issue(2, 2, 20, 1'b0);
    for (int i = 0; i < 40; i++) begin
      int n, w, ab;
      n  = $urandom_range(0, 4);
      w  = $urandom_range(0, 6);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
      issue(n, w, ab, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // Asynchronous reset in the middle of an open pulse.
    chk_en = 1'b0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_pulses = 16'd2;
    cmd_on_cyc = 8'd5;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    chk("pre_reset_valve_open", valve_open, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valve_open", valve_open, 0);
    chk("async_reset_purge_open", purge_open, 0);
    chk("async_reset_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_pulses_sent", pulses_sent, 0);
    chk("post_reset_aborted", aborted, 0);
    chk("post_reset_valve_open", valve_open, 0);
    sb.delete();
    exp_valve.delete();
    exp_purge.delete();
    exp_busy.delete();
    chk_en = 1'b1;
    issue(1, 2, -1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
